// File: rtl/cdc_cmd_stager.sv
// rtl/cdc_cmd_stager.sv - command FIFO and toggle-launch FSM feeding a bus synchronizer
// Entries launch one at a time; tog flips per launch so repeated commands stay distinguishable.
module cdc_cmd_stager #(
  parameter int ARG_W  = 32,
  parameter int CMD_W  = 16,
  parameter int DEPTH  = 4,
  parameter int TO_CYC = 1024
) (
  input  logic                   rst,
  input  logic                   src_clk,
  input  logic                   arg_wr,
  input  logic [ARG_W-1:0]       arg_in,
  input  logic                   cmd_wr,
  input  logic [CMD_W-1:0]       cmd_in,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [CMD_W+ARG_W:0]   bus_out,
  input  logic                   synced,
  output logic                   err_ovf,
  output logic                   err_to,
  input  logic                   err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = CMD_W + ARG_W;
  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ARG_W-1:0] arg_q, arg_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             tog_q, tog_d;
  logic [EW:0]      bus_q, bus_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             ovf_q, ovf_d;
  logic             to_q, to_d;
  logic             pop;
  logic             to_set;
  logic             push_ok;
  logic             push_drop;
  logic [EW-1:0]    head;

  assign full    = (level_q == LW'(DEPTH));
  assign busy    = (state_q != IDLE) || (level_q != '0);
  assign level   = level_q;
  assign bus_out = bus_q;
  assign err_ovf = ovf_q;
  assign err_to  = to_q;
  assign head    = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
  always_comb begin
    arg_d     = arg_wr ? arg_in : arg_q;
    push_ok   = cmd_wr && (!full || pop);
    push_drop = cmd_wr && full && !pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LW'(1);
    end
    ovf_d = push_drop || (ovf_q && !err_clr);
    to_d  = to_set || (to_q && !err_clr);
  end

  always_comb begin
    state_d = state_q;
    tog_d   = tog_q;
    bus_d   = bus_q;
    timer_d = timer_q;
    pop     = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        bus_d   = {~tog_q, head};
        tog_d   = ~tog_q;
        pop     = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // synced may still reflect the previous value during the first WAIT cycle
        if (synced && (timer_q != '0)) begin
          state_d = IDLE;
        end else if (timer_q == TW'(TO_CYC - 1)) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      arg_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tog_q    <= 1'b0;
      bus_q    <= '0;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      arg_q    <= arg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tog_q    <= tog_d;
      bus_q    <= bus_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  always_ff @(posedge src_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {cmd_in, arg_d};
    end
  end

endmodule

// File: tb/tb_cdc_cmd_stager.sv
// tb/tb_cdc_cmd_stager.sv - scoreboard bench for cdc_cmd_stager
module tb_cdc_cmd_stager;
  localparam int ARG_W  = 32;
  localparam int CMD_W  = 16;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 16;
  localparam int BW     = CMD_W + ARG_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             arg_wr = 1'b0;
  logic [ARG_W-1:0] arg_in = '0;
  logic             cmd_wr = 1'b0;
  logic [CMD_W-1:0] cmd_in = '0;
  logic             full;
  logic [2:0]       level;
  logic             busy;
  logic [BW-1:0]    bus_out;
  logic             synced = 1'b1;
  logic             err_ovf;
  logic             err_to;
  logic             err_clr = 1'b0;

  logic [BW-1:0]    sb_q[$];
  int               chg_cyc[$];
  logic [BW-1:0]    prev_bus = '0;
  logic             exp_tog = 1'b0;
  logic [ARG_W-1:0] staged = '0;
  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;

  cdc_cmd_stager #(
    .ARG_W (ARG_W),
    .CMD_W (CMD_W),
    .DEPTH (DEPTH),
    .TO_CYC(TO_CYC)
  ) dut (
    .rst    (rst),
    .src_clk(clk),
    .arg_wr (arg_wr),
    .arg_in (arg_in),
    .cmd_wr (cmd_wr),
    .cmd_in (cmd_in),
    .full   (full),
    .level  (level),
    .busy   (busy),
    .bus_out(bus_out),
    .synced (synced),
    .err_ovf(err_ovf),
    .err_to (err_to),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_bus = '0;
      sb_q.delete();
      chg_cyc.delete();
    end else if (bus_out !== prev_bus) begin
      chg_cyc.push_back(cyc);
      if (sb_q.size() == 0) check("spurious_launch", 64'(bus_out), 64'(prev_bus));
      else check("bus_out", 64'(bus_out), 64'(sb_q.pop_front()));
      prev_bus = bus_out;
    end
  end

  task automatic do_reset();
    rst = 1'b1; arg_wr = 1'b0; cmd_wr = 1'b0; err_clr = 1'b0;
    exp_tog = 1'b0; staged = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_arg(input logic [ARG_W-1:0] a);
    arg_wr = 1'b1; arg_in = a; staged = a;
    @(posedge clk);
    #1 arg_wr = 1'b0;
  endtask

  task automatic push(input logic [CMD_W-1:0] c, input logic wa, input logic [ARG_W-1:0] a,
                      input logic accept);
    cmd_wr = 1'b1; cmd_in = c; arg_wr = wa; arg_in = a;
    if (wa) staged = a;
    if (accept) begin
      exp_tog = ~exp_tog;
      sb_q.push_back({exp_tog, c, staged});
    end
    @(posedge clk);
    #1 cmd_wr = 1'b0; arg_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max_cyc);
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    do_reset();
    @(negedge clk);
    check("rst_bus_out", 64'(bus_out), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_errs", {62'd0, err_ovf, err_to}, 64'd0);

    // basic launch and latency
    @(posedge clk); #1;
    set_arg(32'h1234_5678);
    push(16'h0011, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("lat_level_n1", 64'(level), 64'd1);
    check("lat_bus_n1", 64'(bus_out), 64'd0);
    @(negedge clk);
    check("lat_bus_n2", 64'(bus_out), 64'd0);
    check("lat_busy_n2", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat_bus_n3", 64'(bus_out), 64'h1_0011_1234_5678);
    wait_idle("basic_idle", 20);

    // identical pushes: tog 1 then 0, second waits for synced
    do_reset();
    synced = 1'b0;
    set_arg(32'h1234_5678);
    push(16'h0011, 1'b0, '0, 1'b1);
    push(16'h0011, 1'b0, '0, 1'b1);
    repeat (6) @(negedge clk);
    check("ident_hold_bus", 64'(bus_out), 64'h1_0011_1234_5678);
    check("ident_hold_level", 64'(level), 64'd1);
    check("ident_hold_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 synced = 1'b1;
    wait_idle("ident_idle", 40);
    check("ident_second_bus", 64'(bus_out), 64'h0_0011_1234_5678);
    check("ident_sb_empty", 64'(sb_q.size()), 64'd0);

    // overflow, set-wins on err_clr, push accepted during LAUNCH pop
    do_reset();
    synced = 1'b0;
    push(16'h0100, 1'b1, 32'h5000_0000, 1'b1);
    repeat (3) @(posedge clk); #1;
    push(16'h0101, 1'b1, 32'h5000_0001, 1'b1);
    push(16'h0102, 1'b1, 32'h5000_0002, 1'b1);
    push(16'h0103, 1'b1, 32'h5000_0003, 1'b1);
    push(16'h0104, 1'b1, 32'h5000_0004, 1'b1);
    @(negedge clk);
    check("ovf_level_full", 64'(level), 64'd4);
    check("ovf_pre_err", 64'(err_ovf), 64'd0);
    err_clr = 1'b1;
    push(16'h0105, 1'b0, '0, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    check("ovf_err_set_wins", 64'(err_ovf), 64'd1);
    check("ovf_level_after_drop", 64'(level), 64'd4);
    check("ovf_full", 64'(full), 64'd1);
    @(posedge clk); #1 synced = 1'b1;
    @(posedge clk); #1 synced = 1'b0;
    @(posedge clk); #1;
    push(16'h0106, 1'b1, 32'h5000_0006, 1'b1);
    @(negedge clk);
    check("ovf_pop_push_level", 64'(level), 64'd4);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("ovf_err_clr", 64'(err_ovf), 64'd0);
    synced = 1'b1;
    wait_idle("ovf_idle", 100);
    check("ovf_sb_empty", 64'(sb_q.size()), 64'd0);

    // WAIT timeout
    do_reset();
    synced = 1'b0;
    push(16'h0201, 1'b1, 32'hCAFE_0001, 1'b1);
    push(16'h0202, 1'b1, 32'hCAFE_0002, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_out == '0 && n < 10);
    check("to_first_launch", 64'(bus_out != '0), 64'd1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!err_to && cnt < 40);
    check("to_wait_cycles", 64'(cnt), 64'd16);
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_relaunch", 64'(sb_q.size()), 64'd0);
    check("to_sticky", 64'(err_to), 64'd1);
    @(posedge clk); #1 synced = 1'b1;
    wait_idle("to_idle", 40);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("to_err_clr", 64'(err_to), 64'd0);

    // reset during WAIT with two entries queued
    do_reset();
    synced = 1'b0;
    push(16'h0301, 1'b1, 32'hBEEF_0001, 1'b1);
    push(16'h0302, 1'b1, 32'hBEEF_0002, 1'b1);
    push(16'h0303, 1'b1, 32'hBEEF_0003, 1'b1);
    @(negedge clk);
    check("rstw_level", 64'(level), 64'd2);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rstw_bus_out", 64'(bus_out), 64'd0);
    check("rstw_level0", 64'(level), 64'd0);
    check("rstw_busy", 64'(busy), 64'd0);
    exp_tog = 1'b0; staged = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; synced = 1'b1;
    repeat (10) @(negedge clk);
    check("rstw_no_launch_bus", 64'(bus_out), 64'd0);
    check("rstw_no_launch_busy", 64'(busy), 64'd0);

    // arg bypass and launch spacing
    do_reset();
    synced = 1'b1;
    set_arg(32'h1111_1111);
    push(16'h0042, 1'b1, 32'hAAAA_0000, 1'b1);
    push(16'h0043, 1'b0, '0, 1'b1);
    wait_idle("byp_idle", 40);
    check("byp_sb_empty", 64'(sb_q.size()), 64'd0);
    check("byp_last_bus", 64'(bus_out), 64'h0_0043_AAAA_0000);
    check("spacing_count", 64'(chg_cyc.size()), 64'd2);
    if (chg_cyc.size() == 2) check("spacing_cycles", 64'(chg_cyc[1] - chg_cyc[0]), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
